// File: rtl/psum_mac_engine.sv
// Multi-lane MAC with a two-stage product/accumulate pipeline, neuron packing,
// optional partial-sum read-modify-write, saturation, ReLU and a start/done handshake.
module psum_mac_engine #(
  parameter int LANES  = 4,
  parameter int DW     = 16,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 8,
  parameter int PACK   = 4,
  parameter int ADDR_W = 16,
  parameter int FRAC   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic [ADDR_W-1:0]    cfg_groups,
  input  logic [ADDR_W-1:0]    cfg_base,
  input  logic                 cfg_first,
  input  logic                 cfg_relu,
  input  logic                 in_valid,
  input  logic [LANES*DW-1:0]  ifm,
  input  logic [LANES*DW-1:0]  wgt,
  output logic                 in_ready,
  output logic                 psum_rd_en,
  output logic [ADDR_W-1:0]    psum_rd_addr,
  input  logic [PACK*DW-1:0]   psum_in,
  output logic                 out_valid,
  output logic [ADDR_W-1:0]    out_addr,
  output logic [PACK*DW-1:0]   out_data,
  output logic                 busy,
  output logic                 done
);

  localparam int PD = 2 * DW;
  localparam int PW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [LEN_W-1:0]  ONE_L   = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]     LAST_IX = PW'(PACK - 1);
  localparam logic [DW-1:0]     SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]     SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_DRAIN, S_RD, S_WAIT, S_WR} state_t;

  state_t state_r, state_s;

  logic [LEN_W-1:0]  len_r;
  logic [ADDR_W-1:0] groups_r, group_cnt_r, addr_r;
  logic              first_r, relu_r;
  logic [LEN_W-1:0]  beat_cnt_r;
  logic [PW-1:0]     neuron_cnt_r;

  logic              s1_valid_r, s1_first_r, s1_last_r;
  logic signed [PD-1:0] prod_r [LANES];

  logic signed [ACC_W-1:0] acc_r, sum_s, acc_next_s, shifted_s;
  logic [DW-1:0]     q_s;
  logic [DW-1:0]     pack_r [PACK];
  logic [PW-1:0]     pack_idx_r;
  logic              pack_full_r;

  logic              accept_s, beat_first_s, beat_last_s, group_end_s, last_group_s;
  logic [PACK*DW-1:0] wr_word_s;

  function automatic logic [DW-1:0] sat_acc(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-DW:0] top;
    top = v[ACC_W-1:DW-1];
    if ((&top) || !(|top)) begin
      return v[DW-1:0];
    end else if (v[ACC_W-1]) begin
      return SAT_MIN;
    end else begin
      return SAT_MAX;
    end
  endfunction

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1]) begin
      return s[DW] ? SAT_MIN : SAT_MAX;
    end else begin
      return s[DW-1:0];
    end
  endfunction

  function automatic logic [DW-1:0] relu_fn(input logic en, input logic [DW-1:0] v);
    return (en && v[DW-1]) ? {DW{1'b0}} : v;
  endfunction

  assign accept_s     = in_valid && in_ready;
  assign beat_first_s = (beat_cnt_r == {LEN_W{1'b0}});
  assign beat_last_s  = (beat_cnt_r == len_r - ONE_L);
  assign group_end_s  = accept_s && beat_last_s && (neuron_cnt_r == LAST_IX);
  assign last_group_s = (group_cnt_r == groups_r - ONE_A);

  // Adder tree over lane products and the fixed-point scaling of the running sum.
  always_comb begin
    sum_s = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_s = sum_s + {{(ACC_W-PD){prod_r[l][PD-1]}}, prod_r[l]};
    end
    acc_next_s = (s1_first_r ? {ACC_W{1'b0}} : acc_r) + sum_s;
    shifted_s  = acc_next_s >>> FRAC;
    q_s        = sat_acc(shifted_s);
  end

  // Next-state logic for the group sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:  state_s = (start && (cfg_groups != {ADDR_W{1'b0}})) ? S_ACC : S_IDLE;
      S_ACC:   state_s = group_end_s ? S_DRAIN : S_ACC;
      S_DRAIN: begin
        if (pack_full_r) begin
          state_s = first_r ? S_WR : S_RD;
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_RD:    state_s = S_WAIT;
      S_WAIT:  state_s = S_WR;
      S_WR:    state_s = last_group_s ? S_IDLE : S_ACC;
      default: state_s = S_IDLE;
    endcase
  end

  // Output word: packed slots, merged with the stored psum when coming from WAIT.
  always_comb begin
    wr_word_s = '0;
    for (int s = 0; s < PACK; s++) begin
      wr_word_s[(PACK-1-s)*DW +: DW] = relu_fn(relu_r, (state_r == S_WAIT) ?
          sat_add(pack_r[s], psum_in[(PACK-1-s)*DW +: DW]) : pack_r[s]);
    end
  end

  // Stage 1: register lane products with first/last-of-neuron tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_first_r <= 1'b0;
      s1_last_r  <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        prod_r[l] <= '0;
      end
    end else begin
      s1_valid_r <= accept_s;
      s1_first_r <= beat_first_s;
      s1_last_r  <= beat_last_s;
      if (accept_s) begin
        for (int l = 0; l < LANES; l++) begin
          prod_r[l] <= $signed(ifm[(LANES-1-l)*DW +: DW]) * $signed(wgt[(LANES-1-l)*DW +: DW]);
        end
      end
    end
  end

  // Stage 2: accumulate, and on the last beat of a neuron drop the result into its slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r       <= '0;
      pack_idx_r  <= '0;
      pack_full_r <= 1'b0;
      for (int s = 0; s < PACK; s++) begin
        pack_r[s] <= '0;
      end
    end else begin
      if (s1_valid_r) begin
        acc_r <= acc_next_s;
        if (s1_last_r) begin
          pack_r[pack_idx_r] <= q_s;
          pack_idx_r <= (pack_idx_r == LAST_IX) ? {PW{1'b0}} : pack_idx_r + {{(PW-1){1'b0}}, 1'b1};
        end
      end
      // DRAIN consumes the flag in the same cycle it leaves for RD/WR.
      if (s1_valid_r && s1_last_r && (pack_idx_r == LAST_IX)) begin
        pack_full_r <= 1'b1;
      end else if ((state_r == S_DRAIN) && pack_full_r) begin
        pack_full_r <= 1'b0;
      end
    end
  end

  // Sequencer state, configuration, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      len_r        <= ONE_L;
      groups_r     <= '0;
      group_cnt_r  <= '0;
      addr_r       <= '0;
      first_r      <= 1'b0;
      relu_r       <= 1'b0;
      beat_cnt_r   <= '0;
      neuron_cnt_r <= '0;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      psum_rd_en   <= 1'b0;
      psum_rd_addr <= '0;
      out_valid    <= 1'b0;
      out_addr     <= '0;
      out_data     <= '0;
    end else begin
      state_r    <= state_s;
      in_ready   <= (state_s == S_ACC);
      busy       <= (state_s != S_IDLE);
      psum_rd_en <= (state_s == S_RD);
      out_valid  <= (state_s == S_WR);
      done       <= ((state_r == S_WR) && (state_s == S_IDLE)) ||
                    ((state_r == S_IDLE) && start && (cfg_groups == {ADDR_W{1'b0}}));
      if (state_s == S_RD) begin
        psum_rd_addr <= addr_r;
      end
      if (state_s == S_WR) begin
        out_addr <= addr_r;
        out_data <= wr_word_s;
      end
      case (state_r)
        S_IDLE: begin
          if (start) begin
            len_r        <= (cfg_len == {LEN_W{1'b0}}) ? ONE_L : cfg_len;
            groups_r     <= cfg_groups;
            addr_r       <= cfg_base;
            first_r      <= cfg_first;
            relu_r       <= cfg_relu;
            group_cnt_r  <= '0;
            beat_cnt_r   <= '0;
            neuron_cnt_r <= '0;
          end
        end
        S_ACC: begin
          if (accept_s) begin
            if (beat_last_s) begin
              beat_cnt_r   <= '0;
              neuron_cnt_r <= (neuron_cnt_r == LAST_IX) ? {PW{1'b0}} :
                              neuron_cnt_r + {{(PW-1){1'b0}}, 1'b1};
            end else begin
              beat_cnt_r <= beat_cnt_r + ONE_L;
            end
          end
        end
        S_WR: begin
          addr_r      <= addr_r + ONE_A;
          group_cnt_r <= group_cnt_r + ONE_A;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_mac_engine.sv
// Directed bench for psum_mac_engine: FRAC=0 and FRAC=8 instances share stimulus,
// a reference model fills scoreboard queues that are drained as writes/reads appear.
module tb_psum_mac_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cfg_len = 8'd1;
  logic [15:0] cfg_groups = 16'd0;
  logic [15:0] cfg_base = 16'd0;
  logic        cfg_first = 1'b1;
  logic        cfg_relu = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] ifm = 64'd0;
  logic [63:0] wgt = 64'd0;
  logic [63:0] psum_in = 64'd0;
  logic [63:0] psum_word = 64'd0;

  logic        in_ready_f0, psum_rd_en_f0, out_valid_f0, busy_f0, done_f0;
  logic [15:0] psum_rd_addr_f0, out_addr_f0;
  logic [63:0] out_data_f0;
  logic        in_ready_f8, psum_rd_en_f8, out_valid_f8, busy_f8, done_f8;
  logic [15:0] psum_rd_addr_f8, out_addr_f8;
  logic [63:0] out_data_f8;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q8[$];
  exp_t rdq[$];
  exp_t m0, m8, mr;
  logic [63:0] bi_q[$];
  logic [63:0] bw_q[$];

  psum_mac_engine #(.FRAC(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_groups(cfg_groups),
    .cfg_base(cfg_base), .cfg_first(cfg_first), .cfg_relu(cfg_relu), .in_valid(in_valid),
    .ifm(ifm), .wgt(wgt), .in_ready(in_ready_f0), .psum_rd_en(psum_rd_en_f0),
    .psum_rd_addr(psum_rd_addr_f0), .psum_in(psum_in), .out_valid(out_valid_f0),
    .out_addr(out_addr_f0), .out_data(out_data_f0), .busy(busy_f0), .done(done_f0)
  );

  psum_mac_engine #(.FRAC(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_groups(cfg_groups),
    .cfg_base(cfg_base), .cfg_first(cfg_first), .cfg_relu(cfg_relu), .in_valid(in_valid),
    .ifm(ifm), .wgt(wgt), .in_ready(in_ready_f8), .psum_rd_en(psum_rd_en_f8),
    .psum_rd_addr(psum_rd_addr_f8), .psum_in(psum_in), .out_valid(out_valid_f8),
    .out_addr(out_addr_f8), .out_data(out_data_f8), .busy(busy_f8), .done(done_f8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output-buffer port B: data appears the cycle after the read strobe.
  always @(posedge clk) psum_in <= psum_rd_en_f0 ? psum_word : 64'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input longint v);
    if (v > 64'sd32767) return 16'h7FFF;
    if (v < -64'sd32768) return 16'h8000;
    return v[15:0];
  endfunction

  function automatic logic [15:0] exp_slot(input longint a, input int frac, input logic first,
                                           input logic relu, input logic [15:0] ps);
    longint v;
    logic [15:0] q, r;
    v = (a <<< 24) >>> 24;
    v = v >>> frac;
    q = sat16(v);
    if (first) r = q;
    else r = sat16(longint'($signed(q)) + longint'($signed(ps)));
    if (relu && r[15]) r = 16'h0000;
    return r;
  endfunction

  // Scoreboard drain: writes, psum reads and done pulses.
  always @(negedge clk) begin
    if (out_valid_f0) begin
      chk("wr_expected_f0", 64'(q0.size() != 0), 64'd1);
      if (q0.size() != 0) begin
        m0 = q0.pop_front();
        chk("out_addr_f0", 64'(out_addr_f0), 64'(m0.addr));
        chk("out_data_f0", out_data_f0, m0.data);
        chk("wr_cycle_f0", 64'(cyc), 64'(m0.cyc));
      end
    end
    if (out_valid_f8) begin
      chk("wr_expected_f8", 64'(q8.size() != 0), 64'd1);
      if (q8.size() != 0) begin
        m8 = q8.pop_front();
        chk("out_addr_f8", 64'(out_addr_f8), 64'(m8.addr));
        chk("out_data_f8", out_data_f8, m8.data);
      end
    end
    if (psum_rd_en_f0) begin
      chk("rd_expected", 64'(rdq.size() != 0), 64'd1);
      if (rdq.size() != 0) begin
        mr = rdq.pop_front();
        chk("psum_rd_addr", 64'(psum_rd_addr_f0), 64'(mr.addr));
        chk("rd_cycle", 64'(cyc), 64'(mr.cyc));
      end
    end
    if (done_f0) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_at_done", 64'(busy_f0), 64'd0);
    end
  end

  task automatic add_beat(input logic [63:0] f, input logic [63:0] w);
    bi_q.push_back(f);
    bw_q.push_back(w);
  endtask

  task automatic send_beat(input logic [63:0] f, input logic [63:0] w, output int t);
    int n = 0;
    while (!in_ready_f0 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", 64'(n < 64), 64'd1);
    in_valid = 1'b1;
    ifm = f;
    wgt = w;
    t = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_job(input logic [7:0] len, input logic [15:0] groups, input logic [15:0] base,
                         input logic first, input logic relu, input logic [63:0] pw, input bit poke);
    int le, bi, t, t_prev, d0, n;
    longint a;
    logic [63:0] e0, e8;
    exp_t e;
    le = (len == 8'd0) ? 1 : int'(len);
    psum_word = pw;
    d0 = done_cnt;
    cfg_len = len; cfg_groups = groups; cfg_base = base; cfg_first = first; cfg_relu = relu;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (groups == 16'd0) begin
      chk("done_g0", 64'(done_f0), 64'd1);
      chk("busy_g0", 64'(busy_f0), 64'd0);
      @(posedge clk); #1;
      chk("done_g0_pulse", 64'(done_f0), 64'd0);
      return;
    end
    chk("busy_after_start", 64'(busy_f0), 64'd1);
    bi = 0;
    t = 0;
    for (int g = 0; g < int'(groups); g++) begin
      for (int s = 0; s < 4; s++) begin
        a = 0;
        for (int k = 0; k < le; k++) begin
          t_prev = t;
          if (poke && bi == 2) begin
            start = 1'b1; cfg_base = 16'h1234; cfg_groups = 16'd9;
          end
          send_beat(bi_q[bi], bw_q[bi], t);
          start = 1'b0;
          if (g > 0 && s == 0 && k == 0) chk("regroup_gap", 64'(t - t_prev), first ? 64'd4 : 64'd6);
          for (int l = 0; l < 4; l++) begin
            a += longint'($signed(bi_q[bi][(3-l)*16 +: 16])) * longint'($signed(bw_q[bi][(3-l)*16 +: 16]));
          end
          bi++;
        end
        e0[(3-s)*16 +: 16] = exp_slot(a, 0, first, relu, pw[(3-s)*16 +: 16]);
        e8[(3-s)*16 +: 16] = exp_slot(a, 8, first, relu, pw[(3-s)*16 +: 16]);
      end
      e.addr = 16'(int'(base) + g);
      e.cyc = t + (first ? 3 : 5);
      e.data = e0;
      q0.push_back(e);
      e.data = e8;
      q8.push_back(e);
      if (!first) begin
        e.cyc = t + 3;
        rdq.push_back(e);
      end
    end
    n = 0;
    while (done_cnt == d0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", 64'(done_cnt - d0), 64'd1);
    chk("done_cycle", 64'(done_cyc), 64'(t + (first ? 4 : 6)));
    chk("busy_after_done", 64'(busy_f0), 64'd0);
    chk("sb_empty", 64'(q0.size() + q8.size() + rdq.size()), 64'd0);
  endtask

  task automatic load_basic();
    bi_q.delete(); bw_q.delete();
    repeat (4) add_beat(64'h0001_0001_0001_0001, 64'h0001_0002_0003_0004);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_ctrl", 64'({in_ready_f0, busy_f0, done_f0, out_valid_f0, psum_rd_en_f0}), 64'd0);
    chk("reset_addr", 64'({out_addr_f0, psum_rd_addr_f0}), 64'd0);
    chk("reset_data", out_data_f0, 64'd0);

    // Basic dot products, fresh psum then stored psum.
    load_basic();
    run_job(8'd1, 16'd1, 16'h0020, 1'b1, 1'b0, 64'd0, 1'b0);
    run_job(8'd1, 16'd1, 16'h0020, 1'b0, 1'b0, 64'h0005_FFFD_7FF0_0000, 1'b0);

    // Negative saturation, then the same with ReLU and cfg_len=0.
    bi_q.delete(); bw_q.delete();
    repeat (16) add_beat(64'h7FFF_7FFF_7FFF_7FFF, 64'h8000_8000_8000_8000);
    run_job(8'd4, 16'd1, 16'h0100, 1'b1, 1'b0, 64'd0, 1'b0);
    run_job(8'd0, 16'd1, 16'h0101, 1'b1, 1'b1, 64'd0, 1'b0);

    // Three groups wrapping the address space, psum merge, start ignored while busy.
    bi_q.delete(); bw_q.delete();
    for (int i = 0; i < 24; i++) begin
      logic [63:0] w;
      for (int l = 0; l < 4; l++) w[l*16 +: 16] = 16'($urandom_range(0, 7)) - 16'd4;
      add_beat({$urandom, $urandom}, w);
    end
    run_job(8'd2, 16'd3, 16'hFFFF, 1'b0, 1'b0, 64'h7FFF_8000_0003_FFF0, 1'b1);

    // Fixed-point shift: 0x180, -1, positive and negative overflow.
    bi_q.delete(); bw_q.delete();
    add_beat(64'h0180_0000_0000_0000, 64'h0001_0000_0000_0000);
    add_beat(64'hFFFF_0000_0000_0000, 64'h0001_0000_0000_0000);
    add_beat(64'h0100_0100_0100_0100, 64'h0040_0040_0040_0040);
    add_beat(64'h8000_8000_8000_8000, 64'h7FFF_7FFF_7FFF_7FFF);
    run_job(8'd1, 16'd1, 16'h0200, 1'b1, 1'b0, 64'd0, 1'b0);

    // Zero groups: immediate done, never busy.
    run_job(8'd1, 16'd0, 16'h0300, 1'b1, 1'b0, 64'd0, 1'b0);

    // Abort mid-job with reset.
    bi_q.delete(); bw_q.delete();
    repeat (8) add_beat(64'h0003_0003_0003_0003, 64'h0005_0005_0005_0005);
    cfg_len = 8'd2; cfg_groups = 16'd1; cfg_base = 16'h0400; cfg_first = 1'b1; cfg_relu = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) send_beat(bi_q[k], bw_q[k], t);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_ctrl_f0", 64'({in_ready_f0, busy_f0, done_f0, out_valid_f0, psum_rd_en_f0}), 64'd0);
    chk("abort_addr_f0", 64'({out_addr_f0, psum_rd_addr_f0}), 64'd0);
    chk("abort_data_f0", out_data_f0, 64'd0);
    chk("abort_ctrl_f8", 64'({in_ready_f8, busy_f8, done_f8, out_valid_f8, psum_rd_en_f8}), 64'd0);
    chk("abort_addr_f8", 64'({out_addr_f8, psum_rd_addr_f8}), 64'd0);
    chk("abort_data_f8", out_data_f8, 64'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_idle", 64'({busy_f0, in_ready_f0}), 64'd0);

    load_basic();
    run_job(8'd1, 16'd1, 16'h0020, 1'b1, 1'b0, 64'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
